pwm_deadtime: RTL and testbench
===============================

# pwm_deadtime

Complementary-output dead-time stage placed directly downstream of the 8-bit PWM generator. It takes the single-ended PWM waveform and produces a high-side/low-side gate-drive pair. The two outputs are never active together and are separated by a programmable dead band on every transition. Fault and enable inputs force both outputs low.

## Interface
- DT_W, default 8: width of the dead-time setting, in clock cycles.

- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  output enable; low forces both outputs off.
- dt_i  in  DT_W  dead time in cycles; 0 is treated as 1.
- pwm_i  in  1  PWM input, from the generator's pwm_o.
- fault_i  in  1  external fault; any cycle high trips the block.
- fault_clr_i  in  1  clears the latched fault.
- hi_o  out  1  high-side drive, registered.
- lo_o  out  1  low-side drive, registered.
- fault_o  out  1  sticky fault flag, registered.

## Operation
- pwm_i is registered once into pwm_r, a synchronizer/alignment flop.
- FSM states:
  - OFF: hi_o=0, lo_o=0.
  - LO: lo_o=1.
  - DEAD_R: both outputs 0, heading to HI.
  - HI: hi_o=1.
  - DEAD_F: both outputs 0, heading to LO.
- Dead counter cnt (DT_W bits):
  - On entry to DEAD_R or DEAD_F, cnt is loaded with max(dt_i,1).
  - cnt decrements each cycle while in a dead state.
  - The block leaves the dead state on the cycle where cnt==1.
  - Each dead band therefore lasts exactly max(dt_i,1) cycles.
  - dt_i is sampled only at dead-state entry. Changing dt_i mid-band has no effect on that band.
- Transitions, highest priority first:
  1. fault_i=1 or fault_o=1 or en_i=0 -> OFF.
  2. OFF: pwm_r=1 -> DEAD_R; pwm_r=0 -> DEAD_F. A dead band always precedes the first on-pulse.
  3. LO: pwm_r=1 -> DEAD_R.
  4. HI: pwm_r=0 -> DEAD_F.
  5. DEAD_R: pwm_r=0 -> DEAD_F with cnt reloaded (abort); else cnt==1 -> HI.
  6. DEAD_F: pwm_r=1 -> DEAD_R with cnt reloaded (abort); else cnt==1 -> LO.
- Input pulses shorter than the dead time are swallowed. Neither output turns on for them.
- Outputs are decoded from the next state and registered, so hi_o and lo_o change on the same edge as the state.
- Invariant: hi_o & lo_o is never 1 on any cycle, including reset exit and fault entry.
- Fault:
  - fault_o sets on the cycle after fault_i=1.
  - fault_o clears on the cycle after fault_clr_i=1 with fault_i=0.
  - fault_clr_i and fault_i high together: fault_o stays 1.
  - After the clear, the FSM re-enters through OFF and its dead band.

## Timing
- Reset (rst_i=1 at an edge): state=OFF, cnt=0, pwm_r=0, hi_o=0, lo_o=0, fault_o=0. Reset mid-band aborts the band.
- Falling output edge: the active output drops 2 cycles after the pwm_i edge (1 cycle in pwm_r, 1 cycle in the state register).
- Rising output edge: the incoming output rises max(dt_i,1) cycles after the outgoing output drops.
- Shutdown latency: en_i low or fault_i high at edge k gives both outputs 0 after edge k. This is 1-cycle latency, not delayed by pwm_r.
- Recovery latency: en_i rising at edge k gives OFF->dead at edge k+1. The first output turns on max(dt_i,1) cycles later.
- Output period equals the input period. Duty is reduced by one dead band per edge.

## Structure
- Shared package pwm_pkg holds:
  - state encoding localparams: OFF, LO, DEAD_R, HI, DEAD_F (3-bit);
  - the default DT_W.
  The PWM generator and later stages use the same package.
- Single module, no sub-modules. The dead counter and FSM are small enough to stay inline.
- Expected size is about 150 RTL lines.

## Test plan
- Reset, then en_i=1, dt_i=3, pwm_i=0 -> after 3 dead cycles lo_o=1, hi_o=0. Check hi_o&lo_o==0 on every cycle of all tests.
- pwm_i low-to-high at cycle 100, dt_i=3 -> lo_o falls at cycle 102, hi_o rises at cycle 105. Mirror check on the high-to-low edge.
- dt_i=4 with a 2-cycle pwm_i high pulse -> hi_o never asserts; lo_o resumes after the aborted band.
- dt_i=0 -> 1-cycle dead band on each edge. dt_i=255 with full-period PWM input -> no output overlap and no counter wrap.
- fault_i pulsed mid-HI:
  - hi_o and lo_o are 0 on the next cycle and fault_o=1;
  - fault_clr_i together with fault_i -> fault_o stays 1;
  - fault_clr_i alone -> fault_o clears and outputs restart through a dead band.
- Drive from the PWM generator with duty=64, dt_i=2 -> hi_o high 62 cycles per 256-cycle period, lo_o high 190 cycles per period.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator chain: state encoding and default widths.
package pwm_pkg;

  localparam int PWM_DT_W = 8;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    LO     = 3'd1,
    DEAD_R = 3'd2,
    HI     = 3'd3,
    DEAD_F = 3'd4
  } dt_state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate-drive pair from a single PWM input, with a
// programmable dead band on every transition and a sticky fault shutdown.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = PWM_DT_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [DT_W-1:0] dt_i,
  input  logic            pwm_i,
  input  logic            fault_i,
  input  logic            fault_clr_i,
  output logic            hi_o,
  output logic            lo_o,
  output logic            fault_o
);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0] dt_eff;
  logic            pwm_q;
  logic            fault_q, fault_d;
  logic            hi_q, lo_q;
  logic            kill;

  assign dt_eff  = (dt_i == '0) ? DT_W'(1) : dt_i;
  // Shutdown acts on the raw inputs so it is not delayed by the pwm flop.
  assign kill    = fault_i | fault_q | ~en_i;
  assign fault_d = fault_i | (fault_q & ~fault_clr_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (kill) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = pwm_q ? DEAD_R : DEAD_F;
          cnt_d   = dt_eff;
        end
        LO: if (pwm_q) begin
          state_d = DEAD_R;
          cnt_d   = dt_eff;
        end
        HI: if (!pwm_q) begin
          state_d = DEAD_F;
          cnt_d   = dt_eff;
        end
        DEAD_R: begin
          if (!pwm_q) begin
            state_d = DEAD_F;
            cnt_d   = dt_eff;
          end else if (cnt_q == DT_W'(1)) begin
            state_d = HI;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q - DT_W'(1);
          end
        end
        DEAD_F: begin
          if (pwm_q) begin
            state_d = DEAD_R;
            cnt_d   = dt_eff;
          end else if (cnt_q == DT_W'(1)) begin
            state_d = LO;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q - DT_W'(1);
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OFF;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      fault_q <= 1'b0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_i;
      fault_q <= fault_d;
      hi_q    <= (state_d == HI);
      lo_q    <= (state_d == LO);
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign fault_o = fault_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: edge timing, dead-band abort, dt extremes,
// fault latch/clear, enable shutdown and a generator-driven duty measurement.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       rst, en, pwm, fault, fclr;
  logic [7:0] dt;
  logic       hi, lo, flt;
  int         n_cmp = 0;
  int         n_err = 0;
  bit         overlap = 1'b0;

  pwm_deadtime #(.DT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dt_i(dt), .pwm_i(pwm),
    .fault_i(fault), .fault_clr_i(fclr),
    .hi_o(hi), .lo_o(lo), .fault_o(flt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (hi & lo) overlap = 1'b1;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; dt = 8'd3; pwm = 1'b0; fault = 1'b0; fclr = 1'b0;
    tick(2);
    n_cmp++; if (hi !== 1'b0) begin n_err++; $display("FAIL reset_hi got %b want 0", hi); end
    n_cmp++; if (lo !== 1'b0) begin n_err++; $display("FAIL reset_lo got %b want 0", lo); end
    n_cmp++; if (flt !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", flt); end
    rst = 1'b0; en = 1'b1;
    tick(3);
    n_cmp++; if (lo !== 1'b0) begin n_err++; $display("FAIL init_dead lo got %b want 0", lo); end
    tick(1);
    n_cmp++; if (lo !== 1'b1 || hi !== 1'b0) begin n_err++; $display("FAIL init_lo hi/lo got %b%b want 01", hi, lo); end
  endtask

  task automatic test_edges;
    pwm = 1'b1;
    tick(1);
    n_cmp++; if (lo !== 1'b1) begin n_err++; $display("FAIL rise_lo_hold got %b want 1", lo); end
    tick(1);
    n_cmp++; if (lo !== 1'b0) begin n_err++; $display("FAIL rise_lo_drop got %b want 0", lo); end
    tick(2);
    n_cmp++; if (hi !== 1'b0) begin n_err++; $display("FAIL rise_hi_early got %b want 0", hi); end
    tick(1);
    n_cmp++; if (hi !== 1'b1) begin n_err++; $display("FAIL rise_hi_on got %b want 1", hi); end
    tick(5);
    pwm = 1'b0;
    tick(1);
    n_cmp++; if (hi !== 1'b1) begin n_err++; $display("FAIL fall_hi_hold got %b want 1", hi); end
    tick(1);
    n_cmp++; if (hi !== 1'b0) begin n_err++; $display("FAIL fall_hi_drop got %b want 0", hi); end
    tick(2);
    n_cmp++; if (lo !== 1'b0) begin n_err++; $display("FAIL fall_lo_early got %b want 0", lo); end
    tick(1);
    n_cmp++; if (lo !== 1'b1) begin n_err++; $display("FAIL fall_lo_on got %b want 1", lo); end
  endtask

  task automatic test_swallow;
    bit hi_seen;
    hi_seen = 1'b0;
    dt = 8'd4;
    tick(2);
    pwm = 1'b1;
    tick(1); hi_seen |= hi;
    tick(1); hi_seen |= hi;
    pwm = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(1); hi_seen |= hi; end
    n_cmp++; if (lo !== 1'b0) begin n_err++; $display("FAIL swallow_dead lo got %b want 0", lo); end
    tick(1); hi_seen |= hi;
    n_cmp++; if (lo !== 1'b1) begin n_err++; $display("FAIL swallow_lo_resume got %b want 1", lo); end
    n_cmp++; if (hi_seen !== 1'b0) begin n_err++; $display("FAIL swallow_hi_seen got %b want 0", hi_seen); end
  endtask

  task automatic test_dt_zero;
    dt = 8'd0;
    tick(2);
    pwm = 1'b1;
    tick(2);
    n_cmp++; if ({hi, lo} !== 2'b00) begin n_err++; $display("FAIL dt0_rise_dead hi/lo got %b%b want 00", hi, lo); end
    tick(1);
    n_cmp++; if (hi !== 1'b1) begin n_err++; $display("FAIL dt0_hi_on got %b want 1", hi); end
    pwm = 1'b0;
    tick(2);
    n_cmp++; if ({hi, lo} !== 2'b00) begin n_err++; $display("FAIL dt0_fall_dead hi/lo got %b%b want 00", hi, lo); end
    tick(1);
    n_cmp++; if (lo !== 1'b1) begin n_err++; $display("FAIL dt0_lo_on got %b want 1", lo); end
  endtask

  task automatic test_dt_max;
    dt = 8'd255;
    tick(2);
    pwm = 1'b1;
    tick(2);
    n_cmp++; if (lo !== 1'b0) begin n_err++; $display("FAIL dtmax_lo_drop got %b want 0", lo); end
    tick(254);
    n_cmp++; if (hi !== 1'b0) begin n_err++; $display("FAIL dtmax_hi_early got %b want 0", hi); end
    tick(1);
    n_cmp++; if (hi !== 1'b1) begin n_err++; $display("FAIL dtmax_hi_on got %b want 1", hi); end
    tick(40);
    pwm = 1'b0;
    tick(2);
    n_cmp++; if (hi !== 1'b0) begin n_err++; $display("FAIL dtmax_hi_drop got %b want 0", hi); end
    tick(254);
    n_cmp++; if (lo !== 1'b0) begin n_err++; $display("FAIL dtmax_lo_early got %b want 0", lo); end
    tick(1);
    n_cmp++; if (lo !== 1'b1) begin n_err++; $display("FAIL dtmax_lo_on got %b want 1", lo); end
  endtask

  task automatic test_fault;
    dt = 8'd3;
    pwm = 1'b1;
    tick(6);
    n_cmp++; if (hi !== 1'b1) begin n_err++; $display("FAIL fault_pre_hi got %b want 1", hi); end
    fault = 1'b1;
    tick(1);
    fault = 1'b0;
    n_cmp++; if ({hi, lo, flt} !== 3'b001) begin n_err++; $display("FAIL fault_trip hi/lo/flt got %b%b%b want 001", hi, lo, flt); end
    tick(3);
    n_cmp++; if ({hi, flt} !== 2'b01) begin n_err++; $display("FAIL fault_sticky hi/flt got %b%b want 01", hi, flt); end
    fault = 1'b1; fclr = 1'b1;
    tick(1);
    fault = 1'b0; fclr = 1'b0;
    n_cmp++; if (flt !== 1'b1) begin n_err++; $display("FAIL fault_clr_blocked got %b want 1", flt); end
    tick(1);
    fclr = 1'b1;
    tick(1);
    fclr = 1'b0;
    n_cmp++; if ({hi, flt} !== 2'b00) begin n_err++; $display("FAIL fault_cleared hi/flt got %b%b want 00", hi, flt); end
    tick(3);
    n_cmp++; if (hi !== 1'b0) begin n_err++; $display("FAIL fault_restart_dead got %b want 0", hi); end
    tick(1);
    n_cmp++; if (hi !== 1'b1) begin n_err++; $display("FAIL fault_restart_hi got %b want 1", hi); end
  endtask

  task automatic test_shutdown;
    en = 1'b0;
    tick(1);
    n_cmp++; if ({hi, lo} !== 2'b00) begin n_err++; $display("FAIL en_off hi/lo got %b%b want 00", hi, lo); end
    tick(2);
    en = 1'b1;
    tick(3);
    n_cmp++; if (hi !== 1'b0) begin n_err++; $display("FAIL en_restart_dead got %b want 0", hi); end
    tick(1);
    n_cmp++; if (hi !== 1'b1) begin n_err++; $display("FAIL en_restart_hi got %b want 1", hi); end
    pwm = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_cmp++; if ({hi, lo, flt} !== 3'b000) begin n_err++; $display("FAIL rst_midband got %b%b%b want 000", hi, lo, flt); end
  endtask

  task automatic test_generator;
    int hi_cnt, lo_cnt;
    hi_cnt = 0; lo_cnt = 0;
    dt = 8'd2;
    for (int k = 0; k < 768; k++) begin
      pwm = ((k & 255) < 64);
      tick(1);
      if (k >= 512) begin
        hi_cnt += int'(hi);
        lo_cnt += int'(lo);
      end
    end
    n_cmp++; if (hi_cnt != 62) begin n_err++; $display("FAIL gen_hi_cycles got %0d want 62", hi_cnt); end
    n_cmp++; if (lo_cnt != 190) begin n_err++; $display("FAIL gen_lo_cycles got %0d want 190", lo_cnt); end
  endtask

  task automatic test_overlap;
    n_cmp++; if (overlap !== 1'b0) begin n_err++; $display("FAIL overlap seen got %b want 0", overlap); end
  endtask

  initial begin
    test_reset;
    test_edges;
    test_swallow;
    test_dt_zero;
    test_dt_max;
    test_fault;
    test_shutdown;
    test_generator;
    test_overlap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
